// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one instruction-memory request at a
// time, applies exception/branch redirects, drops stale responses, buffers one instruction.
module fetch_ctrl #(
  parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_jmp_ena,
  input  logic [63:0] excp_pc,
  input  logic        bj_ena,
  input  logic [63:0] new_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        id_ready,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]  r_state;
  logic [63:0] r_fetch_pc;
  logic [63:0] r_req_pc;
  logic        r_drop;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;

  logic        w_redirect;
  logic [63:0] w_target;
  logic        w_accept;
  logic        w_resp;
  logic        w_load;
  logic        w_consume;

  // Handshakes: a request transfers on a cycle where imem_req_valid & imem_req_ready;
  // the buffer transfers to decode on a cycle where inst_valid & id_ready.
  assign w_redirect = excp_jmp_ena | bj_ena;
  assign w_target   = excp_jmp_ena ? excp_pc : new_pc;
  assign w_accept   = (r_state == ST_REQ) & imem_req_ready;
  assign w_resp     = (r_state == ST_WAIT) & imem_resp_valid;
  assign w_load     = w_resp & ~r_drop & ~w_redirect;
  assign w_consume  = r_inst_valid & id_ready;

  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= PC_START;
      r_req_pc   <= 64'd0;
      r_drop     <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_fetch_pc <= w_target;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end

      if (w_accept) begin
        r_req_pc <= r_fetch_pc;
      end

      // A redirect while a request is (or becomes) outstanding marks its response stale.
      if (w_accept) begin
        r_drop <= w_redirect;
      end else if (w_resp) begin
        r_drop <= 1'b0;
      end else if ((r_state == ST_WAIT) && w_redirect) begin
        r_drop <= 1'b1;
      end

      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ: begin
          if (w_accept) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // id_ready in the response cycle is decode's promise to take the new word
          // next cycle, which lets the next request overlap with that consume.
          if (w_resp) r_state <= (w_load && !id_ready) ? ST_HOLD : ST_REQ;
        end
        ST_HOLD: begin
          if (w_redirect || id_ready) r_state <= ST_REQ;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 64'd0;
    end else if (w_redirect) begin
      r_inst_valid <= 1'b0;
    end else if (w_load) begin
      r_inst_valid <= 1'b1;
      r_inst       <= imem_resp_data;
      r_inst_pc    <= r_req_pc;
    end else if (w_consume) begin
      r_inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a free-run vector table, hand-written redirect/reset
// sequences, then random traffic against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp_jmp_ena;
  logic [63:0] excp_pc;
  logic        bj_ena;
  logic [63:0] new_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        id_ready;
  logic [1:0]  o_dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_START(PC_START)) dut (
    .clk(clk), .rst(rst),
    .excp_jmp_ena(excp_jmp_ena), .excp_pc(excp_pc),
    .bj_ena(bj_ena), .new_pc(new_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .id_ready(id_ready), .o_dbg_state(o_dbg_state)
  );

  // ---------------- checkers and driver tasks ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst             = 1'b0;
    excp_jmp_ena    = 1'b0;
    excp_pc         = 64'd0;
    bj_ena          = 1'b0;
    new_pc          = 64'd0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    id_ready        = 1'b1;
  endtask

  // Leaves the DUT in its first post-reset cycle with rst low.
  task automatic do_reset(input string tag);
    clear_inputs();
    rst = 1'b1;
    tick();
    chk1 ({tag, "_rst_req_valid"}, imem_req_valid, 1'b0);
    chk64({tag, "_rst_req_addr"},  imem_req_addr,  PC_START);
    chk1 ({tag, "_rst_inst_valid"}, inst_valid,    1'b0);
    chk32({tag, "_rst_inst"},      inst,           32'd0);
    chk64({tag, "_rst_inst_pc"},   inst_pc,        64'd0);
    chk32({tag, "_rst_state"},     {30'd0, o_dbg_state}, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [63:0] eaddr,
                         input logic eiv, input logic [31:0] einst, input logic [63:0] eipc);
    chk1 ({tag, "_req_valid"},  imem_req_valid, ev);
    chk64({tag, "_req_addr"},   imem_req_addr,  eaddr);
    chk1 ({tag, "_inst_valid"}, inst_valid,     eiv);
    if (eiv) begin
      chk32({tag, "_inst"},    inst,    einst);
      chk64({tag, "_inst_pc"}, inst_pc, eipc);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks what fetch is doing in transaction terms: the boot cycle, whether a
  // request is in flight and whether its answer is already obsolete, whether a
  // delivered word is waiting on decode, and what decode currently sees.
  logic        m_boot, m_inflight, m_stale, m_blocked, m_iv;
  logic [63:0] m_fpc, m_rpc, m_ipc;
  logic [31:0] m_inst;

  function automatic logic m_req_v();
    return !m_boot && !m_inflight && !m_blocked;
  endfunction

  task automatic m_reset();
    m_boot = 1'b1; m_inflight = 1'b0; m_stale = 1'b0; m_blocked = 1'b0;
    m_iv = 1'b0; m_fpc = PC_START; m_rpc = 64'd0; m_ipc = 64'd0; m_inst = 32'd0;
  endtask

  task automatic m_step(input logic rs, input logic redir, input logic [63:0] tgt,
                        input logic rdy, input logic resp, input logic [31:0] rdata,
                        input logic idr);
    logic acc, deliver, got_resp;
    if (rs) begin
      m_reset();
    end else begin
      acc      = m_req_v() && rdy;
      got_resp = m_inflight && resp;
      deliver  = got_resp && !m_stale && !redir;
      if (m_blocked && (redir || idr)) m_blocked = 1'b0;
      if (deliver) m_blocked = !idr;
      if (redir) m_iv = 1'b0;
      else if (deliver) begin
        m_iv = 1'b1; m_inst = rdata; m_ipc = m_rpc;
      end else if (m_iv && idr) m_iv = 1'b0;
      if (got_resp) begin
        m_inflight = 1'b0; m_stale = 1'b0;
      end else if (m_inflight && redir) m_stale = 1'b1;
      if (acc) begin
        m_inflight = 1'b1; m_rpc = m_fpc; m_stale = redir;
      end
      if (redir) m_fpc = tgt;
      else if (acc) m_fpc = m_fpc + 64'd4;
      m_boot = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rsp;
    logic [31:0] data;
    logic        exp_v;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_inst;
    logic [63:0] exp_ipc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int mem_cnt;
    logic acc;
    logic [63:0] tgt;

    // Free-run with zero-wait memory and decode always ready.
    tbl[0] = '{1'b0, 32'h0,         1'b0, 64'h8000_0000, 1'b0, 32'h0,         64'h0};
    tbl[1] = '{1'b0, 32'h0,         1'b1, 64'h8000_0000, 1'b0, 32'h0,         64'h0};
    tbl[2] = '{1'b1, 32'h0000_0013, 1'b0, 64'h8000_0004, 1'b0, 32'h0,         64'h0};
    tbl[3] = '{1'b0, 32'h0,         1'b1, 64'h8000_0004, 1'b1, 32'h0000_0013, 64'h8000_0000};
    tbl[4] = '{1'b1, 32'h00a0_0093, 1'b0, 64'h8000_0008, 1'b0, 32'h0,         64'h0};
    tbl[5] = '{1'b0, 32'h0,         1'b1, 64'h8000_0008, 1'b1, 32'h00a0_0093, 64'h8000_0004};
    tbl[6] = '{1'b1, 32'h1234_5678, 1'b0, 64'h8000_000C, 1'b0, 32'h0,         64'h0};
    tbl[7] = '{1'b0, 32'h0,         1'b1, 64'h8000_000C, 1'b1, 32'h1234_5678, 64'h8000_0008};

    do_reset("tbl");
    for (int i = 0; i < 8; i++) begin
      imem_resp_valid = tbl[i].rsp;
      imem_resp_data  = tbl[i].data;
      chk_out($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_addr,
              tbl[i].exp_iv, tbl[i].exp_inst, tbl[i].exp_ipc);
      tick();
    end
    imem_resp_valid = 1'b0;

    // Decode backpressure: held buffer, no request in HOLD.
    do_reset("bp");
    tick();
    id_ready = 1'b0;
    chk_out("bp_req", 1'b1, 64'h8000_0000, 1'b0, 32'h0, 64'h0);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_0001;
    tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("bp_hold%0d", i), 1'b0, 64'h8000_0004, 1'b1, 32'hdead_0001, 64'h8000_0000);
      tick();
    end
    id_ready = 1'b1;
    chk_out("bp_release", 1'b0, 64'h8000_0004, 1'b1, 32'hdead_0001, 64'h8000_0000);
    tick();
    chk_out("bp_next_req", 1'b1, 64'h8000_0004, 1'b0, 32'h0, 64'h0);
    tick();

    // Branch while the 0x80000004 response is pending.
    bj_ena = 1'b1; new_pc = 64'h8000_0100;
    chk_out("br_wait", 1'b0, 64'h8000_0008, 1'b0, 32'h0, 64'h0);
    tick();
    bj_ena = 1'b0;
    chk_out("br_pending", 1'b0, 64'h8000_0100, 1'b0, 32'h0, 64'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hbad0_bad0;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("br_req", 1'b1, 64'h8000_0100, 1'b0, 32'h0, 64'h0);
    tick();
    chk_out("br_wait2", 1'b0, 64'h8000_0104, 1'b0, 32'h0, 64'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_1111;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("br_deliver", 1'b1, 64'h8000_0104, 1'b1, 32'h0000_1111, 64'h8000_0100);
    tick();

    // Exception and branch together with a response: exception wins, word discarded.
    imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555;
    excp_jmp_ena = 1'b1; excp_pc = 64'h8000_1000;
    bj_ena = 1'b1; new_pc = 64'h8000_0200;
    tick();
    imem_resp_valid = 1'b0; excp_jmp_ena = 1'b0; bj_ena = 1'b0;
    chk_out("ex_req", 1'b1, 64'h8000_1000, 1'b0, 32'h0, 64'h0);

    // Redirect in REQ without acceptance, then coinciding with acceptance.
    imem_req_ready = 1'b0; bj_ena = 1'b1; new_pc = 64'h8000_0300;
    tick();
    chk_out("rq_noacc", 1'b1, 64'h8000_0300, 1'b0, 32'h0, 64'h0);
    imem_req_ready = 1'b1; new_pc = 64'h8000_0400;
    tick();
    bj_ena = 1'b0;
    chk_out("rq_acc_wait", 1'b0, 64'h8000_0400, 1'b0, 32'h0, 64'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h6666_6666;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("rq_refetch", 1'b1, 64'h8000_0400, 1'b0, 32'h0, 64'h0);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_2222;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("rq_deliver", 1'b1, 64'h8000_0404, 1'b1, 32'h0000_2222, 64'h8000_0400);
    tick();

    // Reset while WAIT; late responses in IDLE/REQ are ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("mr_idle", 1'b0, PC_START, 1'b0, 32'h0, 64'h0);
    chk32("mr_inst", inst, 32'd0);
    chk64("mr_inst_pc", inst_pc, 64'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h7777_7777;
    tick();
    chk_out("mr_req", 1'b1, PC_START, 1'b0, 32'h0, 64'h0);
    imem_resp_data = 32'h8888_8888; imem_req_ready = 1'b0;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("mr_req_hold", 1'b1, PC_START, 1'b0, 32'h0, 64'h0);
    imem_req_ready = 1'b1;
    tick();
    chk_out("mr_wait", 1'b0, PC_START + 64'd4, 1'b0, 32'h0, 64'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_4444;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("mr_deliver", 1'b1, PC_START + 64'd4, 1'b1, 32'h0000_4444, PC_START);

    // Random traffic against the reference model.
    do_reset("rnd");
    m_reset();
    mem_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      excp_jmp_ena   = ($urandom_range(0, 24) == 0);
      excp_pc        = PC_START + (64'($urandom_range(0, 255)) << 2);
      bj_ena         = ($urandom_range(0, 11) == 0);
      new_pc         = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                   : PC_START + (64'($urandom_range(0, 255)) << 2);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_resp_valid = (mem_cnt == 1) || ((mem_cnt == 0) && ($urandom_range(0, 15) == 0));
      imem_resp_data = $urandom;

      chk1 ("rnd_req_valid",  imem_req_valid, m_req_v());
      chk64("rnd_req_addr",   imem_req_addr,  m_fpc);
      chk1 ("rnd_inst_valid", inst_valid,     m_iv);
      if (m_iv) begin
        chk32("rnd_inst",    inst,    m_inst);
        chk64("rnd_inst_pc", inst_pc, m_ipc);
      end

      acc = m_req_v() && imem_req_ready && !rst;
      tgt = excp_jmp_ena ? excp_pc : new_pc;
      m_step(rst, excp_jmp_ena | bj_ena, tgt, imem_req_ready, imem_resp_valid,
             imem_resp_data, id_ready);
      if (rst) mem_cnt = 0;
      else if (acc) mem_cnt = int'($urandom_range(1, 3));
      else if (mem_cnt > 0) mem_cnt--;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
